// File: rtl/fpu_sequencer_if.sv
// EX-stage / FPU-core / FP-writeback signal bundle for fpu_sequencer.
// The sequencer uses the slave side. The master side drives the EX-stage inputs and FPU-core returns.
interface fpu_sequencer_if;
    logic        issue_valid;
    logic [4:0]  alu_control;
    logic [4:0]  rd_ex;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] fpu_result;
    logic        fpu_ready;
    logic        fpu_start;
    logic        fpu_abort;
    logic [4:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        stall_ex;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] stall_count;

    modport slave (
        input  issue_valid, alu_control, rd_ex, src_a, src_b, flush, fpu_result, fpu_ready,
        output fpu_start, fpu_abort, fpu_op, fpu_a, fpu_b, stall_ex, wb_valid, wb_rd, wb_data,
               stall_count
    );

    modport master (
        output issue_valid, alu_control, rd_ex, src_a, src_b, flush, fpu_result, fpu_ready,
        input  fpu_start, fpu_abort, fpu_op, fpu_a, fpu_b, stall_ex, wb_valid, wb_rd, wb_data,
               stall_count
    );
endinterface

// File: rtl/fpu_sequencer.sv
// Issue/stall controller for the multi-cycle FPU: latches one FPU op, holds the pipeline
// for the op latency (or until the core is ready), then issues a one-cycle FP writeback.
module fpu_sequencer #(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_DIV  = 10,
    parameter int unsigned LAT_SQRT = 12,
    parameter int unsigned LAT_MISC = 1
) (
    input logic           clk,
    input logic           rstn,
    fpu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_issue;
    logic        w_capture;
    logic        r_fpu_start;
    logic        r_fpu_abort;
    logic [4:0]  r_fpu_op;
    logic [31:0] r_fpu_a;
    logic [31:0] r_fpu_b;
    logic [4:0]  r_rd;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic [15:0] r_stall_count;
    logic        w_stall;

    // Countdown preload: the issue cycle itself is the first latency cycle.
    function automatic logic [3:0] lat_minus1(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001: return 4'(LAT_ADD - 1);
            4'b0010:          return 4'(LAT_MUL - 1);
            4'b0011:          return 4'(LAT_DIV - 1);
            4'b1011:          return 4'(LAT_SQRT - 1);
            default:          return 4'(LAT_MISC - 1);
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        w_issue     = bus.issue_valid && bus.alu_control[4] && (r_state == S_IDLE) && !bus.flush;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = lat_minus1(bus.alu_control[3:0]);
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (bus.fpu_ready) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                end
            end
            // Issue is ignored here: the held instruction retires this cycle.
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_stall = w_issue || (r_state == S_BUSY);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_fpu_start   <= 1'b0;
            r_fpu_abort   <= 1'b0;
            r_fpu_op      <= 5'd0;
            r_fpu_a       <= 32'd0;
            r_fpu_b       <= 32'd0;
            r_rd          <= 5'd0;
            r_wb_rd       <= 5'd0;
            r_wb_data     <= 32'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fpu_start <= w_issue;
            r_fpu_abort <= bus.flush && (r_state != S_IDLE);
            if (w_issue) begin
                r_fpu_op <= bus.alu_control;
                r_fpu_a  <= bus.src_a;
                r_fpu_b  <= bus.src_b;
                r_rd     <= bus.rd_ex;
            end
            if (w_capture) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= bus.fpu_result;
            end
            if (w_stall) r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign bus.stall_ex    = w_stall;
    assign bus.wb_valid    = (r_state == S_DONE) && !bus.flush;
    assign bus.fpu_start   = r_fpu_start;
    assign bus.fpu_abort   = r_fpu_abort;
    assign bus.fpu_op      = r_fpu_op;
    assign bus.fpu_a       = r_fpu_a;
    assign bus.fpu_b       = r_fpu_b;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed table-driven bench for fpu_sequencer plus hand sequences for reset and back-to-back ops.
module tb_fpu_sequencer;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    fpu_sequencer_if bus ();

    fpu_sequencer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          ready_at;
        int          flush_at;
        int          exp_start;
        int          exp_last_stall;
        int          exp_wb;
        int          exp_abort;
        int          exp_stalls;
    } vec_t;

    localparam int NVEC   = 11;
    localparam int NCYC   = 30;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.alu_control = 5'd0;
        bus.rd_ex       = 5'd0;
        bus.src_a       = 32'd0;
        bus.src_b       = 32'd0;
        bus.flush       = 1'b0;
        bus.fpu_result  = 32'd0;
        bus.fpu_ready   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".fpu_start"},   32'(bus.fpu_start),   32'd0);
        chk({tag, ".fpu_abort"},   32'(bus.fpu_abort),   32'd0);
        chk({tag, ".fpu_op"},      32'(bus.fpu_op),      32'd0);
        chk({tag, ".fpu_a"},       bus.fpu_a,            32'd0);
        chk({tag, ".fpu_b"},       bus.fpu_b,            32'd0);
        chk({tag, ".stall_ex"},    32'(bus.stall_ex),    32'd0);
        chk({tag, ".wb_valid"},    32'(bus.wb_valid),    32'd0);
        chk({tag, ".wb_rd"},       32'(bus.wb_rd),       32'd0);
        chk({tag, ".wb_data"},     bus.wb_data,          32'd0);
        chk({tag, ".stall_count"}, 32'(bus.stall_count), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int start_k, n_start, abort_k, n_abort, wb_k, n_wb, last_stall, both;
        logic [15:0] sc0;
        logic [4:0]  got_rd, got_op;
        logic [31:0] got_data, got_a, got_b;
        string       tag;
        start_k = -1; n_start = 0; abort_k = -1; n_abort = 0;
        wb_k = -1; n_wb = 0; last_stall = -1; both = 0;
        got_rd = '0; got_data = '0; got_op = '0; got_a = '0; got_b = '0;
        sc0 = bus.stall_count;
        tag = $sformatf("v%0d", idx);
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            bus.issue_valid = (k == 0);
            bus.alu_control = v.op;
            bus.src_a       = v.a;
            bus.src_b       = v.b;
            bus.rd_ex       = v.rd;
            bus.fpu_result  = v.res;
            bus.fpu_ready   = (k >= v.ready_at);
            bus.flush       = (k == v.flush_at);
            #1;
            if (bus.stall_ex) last_stall = k;
            if (bus.fpu_start) begin
                if (start_k < 0) start_k = k;
                n_start++;
                got_op = bus.fpu_op; got_a = bus.fpu_a; got_b = bus.fpu_b;
            end
            if (bus.fpu_abort) begin
                if (abort_k < 0) abort_k = k;
                n_abort++;
            end
            if (bus.fpu_start && bus.fpu_abort) both++;
            if (bus.wb_valid) begin
                if (wb_k < 0) wb_k = k;
                n_wb++;
                got_rd = bus.wb_rd; got_data = bus.wb_data;
            end
        end
        idle_inputs();
        chk({tag, ".start_cycle"}, start_k, v.exp_start);
        chk({tag, ".start_pulses"}, n_start, (v.exp_start >= 0) ? 1 : 0);
        chk({tag, ".last_stall"}, last_stall, v.exp_last_stall);
        chk({tag, ".wb_cycle"}, wb_k, v.exp_wb);
        chk({tag, ".wb_pulses"}, n_wb, (v.exp_wb >= 0) ? 1 : 0);
        chk({tag, ".abort_cycle"}, abort_k, v.exp_abort);
        chk({tag, ".abort_pulses"}, n_abort, (v.exp_abort >= 0) ? 1 : 0);
        chk({tag, ".start_and_abort"}, both, 0);
        chk({tag, ".stall_count_delta"}, 32'(bus.stall_count - sc0), v.exp_stalls);
        if (v.exp_wb >= 0) begin
            chk({tag, ".wb_rd"}, 32'(got_rd), 32'(v.rd));
            chk({tag, ".wb_data"}, got_data, v.res);
        end
        if (v.exp_start >= 0) begin
            chk({tag, ".fpu_op"}, 32'(got_op), 32'(v.op));
            chk({tag, ".fpu_a"}, got_a, v.a);
            chk({tag, ".fpu_b"}, got_b, v.b);
        end
    endtask

    initial begin
        int wb_n, st_n, st_k0, st_k1, wb_k0, wb_k1, bad;
        logic [4:0]  rd0, rd1;
        logic [31:0] d0, d1;
        logic [15:0] sc0;
        checks = 0;
        errors = 0;

        //            op        a             b             rd     res         rdy flush st last wb abort stalls
        vecs[0]  = '{5'b10000, 32'h3F800000, 32'h40000000, 5'd5,  32'h40400000, 0, -1, 1,  2,  3, -1,  3};
        vecs[1]  = '{5'b10001, 32'h40400000, 32'h3F800000, 5'd7,  32'h40000000, 0, -1, 1,  2,  3, -1,  3};
        vecs[2]  = '{5'b10010, 32'h40000000, 32'h40400000, 5'd9,  32'h40C00000, 0, -1, 1,  3,  4, -1,  4};
        vecs[3]  = '{5'b10011, 32'h41200000, 32'h40000000, 5'd12, 32'h40A00000, 14, -1, 1, 14, 15, -1, 15};
        vecs[4]  = '{5'b11011, 32'h41800000, 32'h00000000, 5'd3,  32'h40800000, 0, -1, 1, 12, 13, -1, 13};
        vecs[5]  = '{5'b10100, 32'hBF800000, 32'h00000000, 5'd31, 32'h3F800000, 0, -1, 1,  1,  2, -1,  2};
        vecs[6]  = '{5'b10010, 32'h12345678, 32'h9ABCDEF0, 5'd4,  32'hDEADBEEF, 0,  2, 1,  2, -1,  3,  3};
        vecs[7]  = '{5'b10000, 32'h11111111, 32'h22222222, 5'd8,  32'hCAFEF00D, 0,  3, 1,  2, -1,  4,  3};
        vecs[8]  = '{5'b11011, 32'h40800000, 32'h00000000, 5'd17, 32'h40000000, 20, -1, 1, 20, 21, -1, 21};
        vecs[9]  = '{5'b10000, 32'h3F800000, 32'h3F800000, 5'd2,  32'h40000000, 0,  0, -1, -1, -1, -1, 0};
        vecs[10] = '{5'b00010, 32'h00000005, 32'h00000003, 5'd6,  32'h00000008, 0, -1, -1, -1, -1, -1, 0};

        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check_all_zero("reset");

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an fdiv
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.alu_control = 5'b10011;
        bus.src_a = 32'h40000000; bus.src_b = 32'h3F800000; bus.rd_ex = 5'd10;
        bus.fpu_result = 32'h40000000; bus.fpu_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.issue_valid = 1'b0;
            if (k == 4) rstn = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_all_zero("rst_midop");
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (bus.wb_valid || bus.stall_ex || bus.fpu_start) bad++;
        end
        chk("rst_midop.no_activity_after", bad, 0);
        idle_inputs();

        // Back-to-back: fadd then fmul with issue_valid held high
        sc0 = bus.stall_count;
        wb_n = 0; st_n = 0; st_k0 = -1; st_k1 = -1; wb_k0 = -1; wb_k1 = -1;
        rd0 = '0; rd1 = '0; d0 = '0; d1 = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.issue_valid = (k <= 4);
            bus.alu_control = (k <= 3) ? 5'b10000 : 5'b10010;
            bus.rd_ex       = (k <= 3) ? 5'd5 : 5'd6;
            bus.src_a       = 32'h3F800000;
            bus.src_b       = 32'h40000000;
            bus.fpu_result  = (k <= 3) ? 32'h40400000 : 32'h40000000;
            bus.fpu_ready   = 1'b1;
            #1;
            if (bus.fpu_start) begin
                if (st_n == 0) st_k0 = k; else st_k1 = k;
                st_n++;
            end
            if (bus.wb_valid) begin
                if (wb_n == 0) begin wb_k0 = k; rd0 = bus.wb_rd; d0 = bus.wb_data; end
                else begin wb_k1 = k; rd1 = bus.wb_rd; d1 = bus.wb_data; end
                wb_n++;
            end
        end
        idle_inputs();
        chk("b2b.start_pulses", st_n, 2);
        chk("b2b.start0_cycle", st_k0, 1);
        chk("b2b.start1_cycle", st_k1, 5);
        chk("b2b.wb_pulses", wb_n, 2);
        chk("b2b.wb0_cycle", wb_k0, 3);
        chk("b2b.wb1_cycle", wb_k1, 8);
        chk("b2b.wb0_rd", 32'(rd0), 32'd5);
        chk("b2b.wb0_data", d0, 32'h40400000);
        chk("b2b.wb1_rd", 32'(rd1), 32'd6);
        chk("b2b.wb1_data", d1, 32'h40000000);
        chk("b2b.stall_count_delta", 32'(bus.stall_count - sc0), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
